// File: rtl/fib_caller_if.sv
// Signal bundle for fib_caller: request stream, response stream and the fib callee
// call handshake. The master modport is the caller's view; slave is everything around it.
interface fib_caller_if #(
  parameter int CW = 16
);
  logic               req_valid;
  logic               req_ready;
  logic signed [31:0] req_n;

  logic               rsp_valid;
  logic               rsp_ready;
  logic        [31:0] rsp_result;
  logic      [CW-1:0] rsp_cycles;
  logic               rsp_err;

  logic               fib_start;
  logic signed [31:0] fib_args_n;
  logic               fib_ready;
  logic               fib_done;
  logic        [31:0] fib_result;

  modport master (
    input  req_valid, req_n, rsp_ready, fib_ready, fib_done, fib_result,
    output req_ready, rsp_valid, rsp_result, rsp_cycles, rsp_err, fib_start, fib_args_n
  );

  modport slave (
    output req_valid, req_n, rsp_ready, fib_ready, fib_done, fib_result,
    input  req_ready, rsp_valid, rsp_result, rsp_cycles, rsp_err, fib_start, fib_args_n
  );
endinterface

// File: rtl/fib_caller.sv
// Issues one fib callee call per accepted request and returns result, latency and a
// timeout flag. One call outstanding; every output comes straight from a flop.
module fib_caller #(
  parameter int CW      = 16,
  parameter int TIMEOUT = 0
) (
  input  logic         __func_clock,
  input  logic         __func_reset,
  fib_caller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RESP,
    S_DRAIN
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam bit            TO_EN   = (TIMEOUT != 0);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;

  logic          req_ready_q, req_ready_nxt;
  logic          rsp_valid_q, rsp_valid_nxt;
  logic          rsp_err_q, rsp_err_nxt;
  logic          fib_start_q, fib_start_nxt;
  logic   [31:0] fib_args_n_q, fib_args_n_nxt;
  logic   [31:0] rsp_result_q, rsp_result_nxt;
  logic [CW-1:0] rsp_cycles_q, rsp_cycles_nxt;

  logic          complete;
  logic          timeout_hit;

  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  // A sticky done from a previous call must not count, so completion is BUSY-only.
  assign complete = (state == S_BUSY) && bus.fib_ready && bus.fib_done;

  assign timeout_hit = TO_EN && ((state == S_ISSUE) || (state == S_BUSY)) &&
                       (cnt == TO_LAST) && !complete;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_nxt      = state;
    cnt_nxt        = cnt;
    rsp_valid_nxt  = rsp_valid_q;
    rsp_err_nxt    = rsp_err_q;
    fib_start_nxt  = fib_start_q;
    fib_args_n_nxt = fib_args_n_q;
    rsp_result_nxt = rsp_result_q;
    rsp_cycles_nxt = rsp_cycles_q;

    case (state)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          fib_args_n_nxt = bus.req_n;
          cnt_nxt        = '0;
          fib_start_nxt  = 1'b1;
          state_nxt      = S_ISSUE;
        end
      end

      S_ISSUE, S_BUSY: begin
        cnt_nxt = cnt_inc;
        if (complete) begin
          rsp_result_nxt = bus.fib_result;
          rsp_err_nxt    = 1'b0;
          rsp_cycles_nxt = cnt_inc;
          rsp_valid_nxt  = 1'b1;
          state_nxt      = S_RESP;
        end else if (timeout_hit) begin
          rsp_result_nxt = '0;
          rsp_err_nxt    = 1'b1;
          rsp_cycles_nxt = cnt_inc;
          rsp_valid_nxt  = 1'b1;
          fib_start_nxt  = 1'b0;
          state_nxt      = S_RESP;
        end else if ((state == S_ISSUE) && !bus.fib_ready) begin
          // Callee left its wait state: the start has been taken.
          fib_start_nxt = 1'b0;
          state_nxt     = S_BUSY;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = rsp_err_q ? S_DRAIN : S_IDLE;
        end
      end

      S_DRAIN: begin
        // The abandoned call must finish before a new start can be judged accepted.
        if (bus.fib_ready) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    req_ready_nxt = (state_nxt == S_IDLE);
  end

  always_ff @(posedge __func_clock or posedge __func_reset) begin
    if (__func_reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      fib_start_q  <= 1'b0;
      fib_args_n_q <= '0;
      rsp_result_q <= '0;
      rsp_cycles_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      req_ready_q  <= req_ready_nxt;
      rsp_valid_q  <= rsp_valid_nxt;
      rsp_err_q    <= rsp_err_nxt;
      fib_start_q  <= fib_start_nxt;
      fib_args_n_q <= fib_args_n_nxt;
      rsp_result_q <= rsp_result_nxt;
      rsp_cycles_q <= rsp_cycles_nxt;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.fib_start  = fib_start_q;
  assign bus.fib_args_n = fib_args_n_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_cycles = rsp_cycles_q;

endmodule

// File: tb/tb_fib_caller.sv
// Directed bench for fib_caller: unit 0 has the timeout disabled, unit 1 uses TIMEOUT=32.
// Each unit drives its own behavioural fib callee with adjustable latency, hang and stub value.
module tb_fib_caller;

  localparam int CW = 16;

  logic __func_clock = 1'b0;
  logic __func_reset;

  always #5 __func_clock = ~__func_clock;

  fib_caller_if #(.CW(CW)) bus [2] ();

  fib_caller #(.CW(CW), .TIMEOUT(0)) u_dut0 (
    .__func_clock (__func_clock),
    .__func_reset (__func_reset),
    .bus          (bus[0])
  );

  fib_caller #(.CW(CW), .TIMEOUT(32)) u_dut1 (
    .__func_clock (__func_clock),
    .__func_reset (__func_reset),
    .bus          (bus[1])
  );

  logic          req_valid    [2];
  logic   [31:0] req_n        [2];
  logic          rsp_ready    [2];
  logic          req_ready_o  [2];
  logic          rsp_valid_o  [2];
  logic          rsp_err_o    [2];
  logic          fib_start_o  [2];
  logic   [31:0] rsp_result_o [2];
  logic   [31:0] fib_args_o   [2];
  logic [CW-1:0] rsp_cycles_o [2];

  // Callee model state and knobs
  logic          c_ready  [2];
  logic          c_done   [2];
  logic   [31:0] c_result [2];
  int            c_left   [2];
  int            cal_lat  [2];
  bit            cal_hang [2];
  bit            cal_fixed[2];
  logic   [31:0] cal_val  [2];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_wire
    assign bus[g].req_valid  = req_valid[g];
    assign bus[g].req_n      = req_n[g];
    assign bus[g].rsp_ready  = rsp_ready[g];
    assign bus[g].fib_ready  = c_ready[g];
    assign bus[g].fib_done   = c_done[g];
    assign bus[g].fib_result = c_result[g];
    assign req_ready_o[g]    = bus[g].req_ready;
    assign rsp_valid_o[g]    = bus[g].rsp_valid;
    assign rsp_err_o[g]      = bus[g].rsp_err;
    assign fib_start_o[g]    = bus[g].fib_start;
    assign rsp_result_o[g]   = bus[g].rsp_result;
    assign fib_args_o[g]     = bus[g].fib_args_n;
    assign rsp_cycles_o[g]   = bus[g].rsp_cycles;
  end

  function automatic logic [31:0] fib_ref(input int n);
    logic [31:0] a, b, t;
    a = 0;
    b = 1;
    for (int i = 1; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Callee: takes start only while ready, stays busy cal_lat cycles, done is sticky.
  always @(posedge __func_clock or posedge __func_reset) begin
    if (__func_reset) begin
      for (int g = 0; g < 2; g++) begin
        c_ready[g]  <= 1'b1;
        c_done[g]   <= 1'b0;
        c_result[g] <= '0;
        c_left[g]   <= 0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (c_ready[g] && fib_start_o[g]) begin
          c_ready[g]  <= 1'b0;
          c_done[g]   <= 1'b0;
          c_left[g]   <= cal_lat[g];
          c_result[g] <= cal_fixed[g] ? cal_val[g] : fib_ref($signed(fib_args_o[g]));
        end else if (!c_ready[g] && !cal_hang[g]) begin
          if (c_left[g] <= 1) begin
            c_ready[g] <= 1'b1;
            c_done[g]  <= 1'b1;
          end else begin
            c_left[g] <= c_left[g] - 1;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic send(input int u, input int n, output bit ok);
    ok = 1'b0;
    req_valid[u] = 1'b1;
    req_n[u]     = n;
    for (int i = 0; i < 200; i++) begin
      if (req_ready_o[u]) begin
        @(negedge __func_clock);
        ok = 1'b1;
        break;
      end
      @(negedge __func_clock);
    end
    req_valid[u] = 1'b0;
  endtask

  // cyc counts edges from acceptance to completion, i.e. the ISSUE+BUSY edges.
  task automatic wait_rsp(input int u, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid_o[u]) begin
        ok = 1'b1;
        break;
      end
      @(negedge __func_clock);
      cyc++;
    end
  endtask

  task automatic do_call(input int u, input int n, input logic [31:0] exp_res,
                         input bit exp_err, input int exp_cyc, input string tag);
    bit ok;
    int cyc;
    send(u, n, ok);
    check({tag, "_accept"}, ok, 1);
    wait_rsp(u, cyc, ok);
    check({tag, "_rsp_seen"}, ok, 1);
    check({tag, "_result"}, rsp_result_o[u], exp_res);
    check({tag, "_err"}, rsp_err_o[u], exp_err);
    check({tag, "_cycles"}, rsp_cycles_o[u], exp_cyc);
    rsp_ready[u] = 1'b1;
    @(negedge __func_clock);
  endtask

  task automatic check_reset_vals(input int u, input string tag);
    check({tag, "_req_ready"}, req_ready_o[u], 0);
    check({tag, "_rsp_valid"}, rsp_valid_o[u], 0);
    check({tag, "_fib_start"}, fib_start_o[u], 0);
    check({tag, "_rsp_err"}, rsp_err_o[u], 0);
    check({tag, "_fib_args"}, fib_args_o[u], 0);
    check({tag, "_rsp_result"}, rsp_result_o[u], 0);
    check({tag, "_rsp_cycles"}, rsp_cycles_o[u], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit stable;
    bit seen_rsp;
    int cyc;
    int rdy_at;

    __func_reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0;
      req_n[g]     = '0;
      rsp_ready[g] = 1'b1;
      cal_lat[g]   = 4;
      cal_hang[g]  = 1'b0;
      cal_fixed[g] = 1'b0;
      cal_val[g]   = '0;
    end

    repeat (3) @(negedge __func_clock);
    check_reset_vals(0, "rst0");
    check_reset_vals(1, "rst1");
    __func_reset = 1'b0;
    @(negedge __func_clock);
    check("idle_req_ready0", req_ready_o[0], 1);
    check("idle_req_ready1", req_ready_o[1], 1);

    // Real fib, latency 4: ISSUE+BUSY = latency + 2
    do_call(0, 10, 32'd55, 1'b0, 6, "fib10");
    do_call(0, 0, 32'd0, 1'b0, 6, "fib0");
    do_call(0, 1, 32'd1, 1'b0, 6, "fib1");
    do_call(0, -5, 32'd0, 1'b0, 6, "fibm5");
    do_call(0, 46, 32'd1836311903, 1'b0, 6, "fib46");

    // Fixed 7-cycle callee: start held until ready falls, 9 counted edges
    cal_lat[0] = 7;
    send(0, 3, ok);
    check("stub7_accept", ok, 1);
    check("stub7_start_k", fib_start_o[0], 1);
    check("stub7_args", fib_args_o[0], 3);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid_o[0]) break;
      @(negedge __func_clock);
      cyc++;
      if (cyc == 1) begin
        check("stub7_ready_fell", c_ready[0], 0);
        check("stub7_start_held", fib_start_o[0], 1);
      end
      if (cyc == 2) check("stub7_start_drop", fib_start_o[0], 0);
    end
    check("stub7_rsp_seen", rsp_valid_o[0], 1);
    check("stub7_measured", cyc, 9);
    check("stub7_cycles", rsp_cycles_o[0], cyc);
    check("stub7_result", rsp_result_o[0], 2);
    @(negedge __func_clock);

    // Back-to-back with a stalled response stream
    cal_lat[0]   = 3;
    rsp_ready[0] = 1'b0;
    send(0, 4, ok);
    check("b2b_accept1", ok, 1);
    req_valid[0] = 1'b1;
    req_n[0]     = 6;
    wait_rsp(0, cyc, ok);
    check("b2b_rsp1_seen", ok, 1);
    check("b2b_result1", rsp_result_o[0], 3);
    check("b2b_cycles1", rsp_cycles_o[0], 5);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge __func_clock);
      if (!rsp_valid_o[0] || rsp_result_o[0] != 32'd3 || rsp_cycles_o[0] != CW'(5) ||
          rsp_err_o[0] || req_ready_o[0])
        stable = 1'b0;
    end
    check("b2b_stall_stable", stable, 1);
    rsp_ready[0] = 1'b1;
    @(negedge __func_clock);
    check("b2b_consumed", rsp_valid_o[0], 0);
    check("b2b_req_ready_r1", req_ready_o[0], 1);
    @(negedge __func_clock);
    req_valid[0] = 1'b0;
    check("b2b_accept2_start", fib_start_o[0], 1);
    check("b2b_accept2_args", fib_args_o[0], 6);
    check("b2b_accept2_busy", req_ready_o[0], 0);
    wait_rsp(0, cyc, ok);
    check("b2b_rsp2_seen", ok, 1);
    check("b2b_result2", rsp_result_o[0], 8);
    @(negedge __func_clock);

    // Completion on the last allowed edge wins over the timeout
    cal_fixed[1] = 1'b1;
    cal_val[1]   = 32'd777;
    cal_lat[1]   = 30;
    do_call(1, 9, 32'd777, 1'b0, 32, "to_edge_ok");

    // One cycle later is a timeout
    cal_val[1] = 32'd555;
    cal_lat[1] = 31;
    do_call(1, 9, 32'd0, 1'b1, 32, "to_edge_late");

    // Hung callee: timeout, then the late finish with 99 must produce no response
    cal_hang[1] = 1'b1;
    cal_val[1]  = 32'd99;
    cal_lat[1]  = 4;
    do_call(1, 7, 32'd0, 1'b1, 32, "hang");
    check("hang_drain_hold", req_ready_o[1], 0);
    cal_hang[1] = 1'b0;
    seen_rsp    = 1'b0;
    rdy_at      = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge __func_clock);
      if (rsp_valid_o[1]) seen_rsp = 1'b1;
      if (c_ready[1] && rdy_at < 0) begin
        rdy_at = i;
        check("drain_ready_seen_hold", req_ready_o[1], 0);
      end else if (rdy_at >= 0 && i == rdy_at + 1) begin
        check("drain_release", req_ready_o[1], 1);
      end
    end
    check("drain_callee_done", rdy_at >= 0, 1);
    check("no_stale_rsp", seen_rsp, 0);
    cal_fixed[1] = 1'b0;
    cal_lat[1]   = 3;
    do_call(1, 2, 32'd1, 1'b0, 5, "after_to");

    // Asynchronous reset in the middle of a call
    cal_lat[0] = 20;
    send(0, 5, ok);
    check("rstmid_accept", ok, 1);
    repeat (3) @(negedge __func_clock);
    check("rstmid_in_busy", fib_start_o[0], 0);
    #2;
    __func_reset = 1'b1;
    #1;
    check_reset_vals(0, "rstmid");
    @(negedge __func_clock);
    __func_reset = 1'b0;
    cal_lat[0] = 4;
    @(negedge __func_clock);
    do_call(0, 5, 32'd5, 1'b0, 6, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
